pc_redirect: RTL and testbench
==============================

PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset.
REQ-002 SHALL provide parameter FLUSH_CYCLES, default 2, which is the number of cycles flush is held after a redirect; legal range 1..7.
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL provide port stall  input  1  hazard stall; holds the sequential PC.
REQ-006 SHALL provide port br_valid  input  1  the EX-stage instruction is a branch or jump.
REQ-007 SHALL provide port br_taken  input  1  conditional outcome from the branch comparator; 1 = taken.
REQ-008 SHALL provide port br_is_jal  input  1  unconditional PC-relative jump.
REQ-009 SHALL provide port br_is_jalr  input  1  unconditional register-indirect jump.
REQ-010 SHALL provide port br_pc  input  32  PC of the EX-stage instruction.
REQ-011 SHALL provide port br_imm  input  32  sign-extended offset.
REQ-012 SHALL provide port br_rs1  input  32  rs1 value, used for JALR only.
REQ-013 SHALL provide port pc_out  output  32  current fetch address.
REQ-014 SHALL provide port fetch_valid  output  1  pc_out is a valid fetch request.
REQ-015 SHALL provide port flush  output  1  kill the younger IF/ID instructions.
REQ-016 SHALL provide port redirect  output  1  one-cycle pulse: pc_out was just loaded from a branch target.
REQ-017 SHALL provide port misalign  output  1  sticky fault: a target was not word-aligned.
REQ-018 SHALL provide port link_addr  output  32  br_pc+4, combinational, for the JAL/JALR rd writeback.

Function
REQ-019 SHALL implement three states: RUN, FLUSH and HALT.
REQ-020 SHALL compute target = (br_rs1+br_imm) & ~32'h1 when br_is_jalr = 1, otherwise br_pc+br_imm; 32-bit modulo arithmetic, carry discarded.
REQ-021 SHALL define take = br_valid & (br_taken | br_is_jal | br_is_jalr), evaluated only in RUN.
REQ-022 SHALL, in RUN with take = 1 and target[1:0] = 0: load pc_out <= target, set redirect = 1 for the next cycle only, set flush = 1 for exactly FLUSH_CYCLES cycles starting the next cycle, and enter FLUSH.
REQ-023 SHALL give take priority over stall: a taken branch redirects even when stall = 1.
REQ-024 SHALL, in RUN with take = 0: load pc_out <= pc_out+4 when stall = 0, or hold pc_out when stall = 1; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-025 SHALL, in FLUSH: ignore br_* inputs, advance pc_out by +4 unless stall = 1, and decrement the flush counter every cycle regardless of stall.
REQ-026 SHALL return from FLUSH to RUN in the cycle after the last flush = 1 cycle; a branch presented in that cycle is evaluated normally.
REQ-027 SHALL, on take with target[1:0] != 0: leave pc_out unchanged, set misalign = 1 and fetch_valid = 0 from the next cycle, and enter HALT; no redirect or flush pulse.
REQ-028 SHALL hold HALT, with pc_out frozen and all inputs except rst_n ignored, until reset.
REQ-029 SHALL keep fetch_valid = 1 in RUN and FLUSH.
REQ-030 SHALL compute link_addr = br_pc+4 with wrap, independent of state.

Reset
REQ-031 SHALL, on a rising edge with rst_n = 0: pc_out = RESET_PC, fetch_valid = 0, flush = 0, redirect = 0, misalign = 0, flush counter = 0, state = RUN.
REQ-032 SHALL assert fetch_valid = 1 on the first edge with rst_n = 1.
REQ-033 SHALL let reset asserted in FLUSH or HALT abort immediately to the reset values in REQ-031.
REQ-034 SHALL not change state while rst_n = 0, regardless of the inputs.

Verification
REQ-035 SHALL cover sequential wrap: reset with RESET_PC = 32'hFFFF_FFF8, release, no branches -> pc_out = FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-036 SHALL cover a taken BEQ: br_pc = 0x100, br_imm = 0x40, br_taken = 1 -> next cycle pc_out = 0x140, redirect = 1 for 1 cycle, flush = 1 for 2 cycles, then pc_out = 0x144, 0x148.
REQ-037 SHALL cover JALR bit-0 masking: br_rs1 = 0x2001, br_imm = 0x4, br_is_jalr = 1 -> pc_out = 0x2004, link_addr = br_pc+4.
REQ-038 SHALL cover the misaligned target: br_pc = 0x200, br_imm = 0x2, br_is_jal = 1 -> misalign = 1, fetch_valid = 0, pc_out frozen; later inputs ignored; reset clears the fault.
REQ-039 SHALL cover stall and flush interaction: stall = 1 for 3 cycles with br_taken = 1 at cycle 2 -> redirect occurs despite stall; flush lasts 2 cycles while pc_out holds; a branch during flush is ignored.
REQ-040 SHALL cover reset mid-FLUSH: rst_n = 0 in the first flush cycle -> next edge pc_out = RESET_PC, flush = 0, redirect = 0.

Source files
------------

// File: rtl/pc_redirect.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect
//  Purpose  : Fetch PC generator with branch/jump redirect, post-redirect
//             IF/ID flush window and sticky misaligned-target halt.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_redirect #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic        br_is_jal,
   input  logic        br_is_jalr,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_imm,
   input  logic [31:0] br_rs1,
   output logic [31:0] pc_out,
   output logic        fetch_valid,
   output logic        flush,
   output logic        redirect,
   output logic        misalign,
   output logic [31:0] link_addr
);

   // Flush window length; legal values 1..7 fit the 3-bit counter.
   localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t      r_state;
   logic [2:0]  r_flush_cnt;
   logic [31:0] r_pc;
   logic        r_fetch_valid;
   logic        r_flush;
   logic        r_redirect;
   logic        r_misalign;

   logic [31:0] w_jalr_sum;
   logic [31:0] w_target;
   logic [31:0] w_pc_inc;
   logic        w_take;
   logic        w_aligned;

   // JALR clears bit 0 of the register-relative sum; everything else is PC-relative.
   assign w_jalr_sum = br_rs1 + br_imm;
   assign w_target   = br_is_jalr ? (w_jalr_sum & ~32'h1) : (br_pc + br_imm);
   assign w_aligned  = (w_target[1:0] == 2'b00);
   assign w_take     = br_valid & (br_taken | br_is_jal | br_is_jalr);
   assign w_pc_inc   = r_pc + 32'd4;

   assign pc_out      = r_pc;
   assign fetch_valid = r_fetch_valid;
   assign flush       = r_flush;
   assign redirect    = r_redirect;
   assign misalign    = r_misalign;
   assign link_addr   = br_pc + 32'd4;

   // Control FSM: sequential fetch, redirect with flush window, fault halt.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_flush_cnt   <= 3'd0;
         r_pc          <= RESET_PC;
         r_fetch_valid <= 1'b0;
         r_flush       <= 1'b0;
         r_redirect    <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_redirect <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (w_take && w_aligned) begin
                  // Taken branch wins over stall.
                  r_pc          <= w_target;
                  r_redirect    <= 1'b1;
                  r_flush       <= 1'b1;
                  r_flush_cnt   <= c_flush_init;
                  r_fetch_valid <= 1'b1;
                  r_state       <= ST_FLUSH;
               end else if (w_take) begin
                  // Misaligned target: freeze the PC and stop fetching for good.
                  r_misalign    <= 1'b1;
                  r_fetch_valid <= 1'b0;
                  r_state       <= ST_HALT;
               end else begin
                  r_fetch_valid <= 1'b1;
                  if (!stall) begin
                     r_pc <= w_pc_inc;
                  end
               end
            end
            ST_FLUSH: begin
               // Counter holds the flush cycles still to be shown, including this one.
               r_flush_cnt <= r_flush_cnt - 3'd1;
               if (r_flush_cnt <= 3'd1) begin
                  r_flush <= 1'b0;
                  r_state <= ST_RUN;
               end
               if (!stall) begin
                  r_pc <= w_pc_inc;
               end
            end
            ST_HALT: begin
               r_fetch_valid <= 1'b0;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_redirect
//  Purpose  : Self-checking bench for pc_redirect with a cycle-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_redirect;

   localparam logic [31:0] RESET_PC     = 32'hFFFF_FFF8;
   localparam int          FLUSH_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        br_valid;
   logic        br_taken;
   logic        br_is_jal;
   logic        br_is_jalr;
   logic [31:0] br_pc;
   logic [31:0] br_imm;
   logic [31:0] br_rs1;
   logic [31:0] pc_out;
   logic        fetch_valid;
   logic        flush;
   logic        redirect;
   logic        misalign;
   logic [31:0] link_addr;

   int n_cmp = 0;
   int n_bad = 0;

   pc_redirect #(
      .RESET_PC     (RESET_PC),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .br_valid    (br_valid),
      .br_taken    (br_taken),
      .br_is_jal   (br_is_jal),
      .br_is_jalr  (br_is_jalr),
      .br_pc       (br_pc),
      .br_imm      (br_imm),
      .br_rs1      (br_rs1),
      .pc_out      (pc_out),
      .fetch_valid (fetch_valid),
      .flush       (flush),
      .redirect    (redirect),
      .misalign    (misalign),
      .link_addr   (link_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Model: a cycle index plus the index at which the flush window ends.
   // ---------------------------------------------------------------------
   logic [31:0] m_pc;
   logic        m_fv, m_flush, m_red, m_mis, m_halt;
   logic        m_ready = 1'b0;
   longint      cyc, flush_end;

   task automatic model_step();
      logic [31:0] tgt;
      logic        in_run, take;
      if (!rst_n) begin
         m_pc = RESET_PC; m_fv = 1'b0; m_flush = 1'b0; m_red = 1'b0;
         m_mis = 1'b0; m_halt = 1'b0; cyc = 0; flush_end = 0; m_ready = 1'b1;
      end else if (m_ready) begin
         in_run = !m_halt && (cyc >= flush_end);
         if (br_is_jalr) tgt = (br_rs1 + br_imm) & 32'hFFFF_FFFE;
         else            tgt = br_pc + br_imm;
         take  = in_run && br_valid && (br_taken || br_is_jal || br_is_jalr);
         m_red = 1'b0;
         if (m_halt) begin
            m_fv = 1'b0;
         end else if (take && (tgt % 4 == 0)) begin
            m_pc = tgt; m_red = 1'b1; m_fv = 1'b1;
            flush_end = cyc + 1 + FLUSH_CYCLES;
         end else if (take) begin
            m_halt = 1'b1; m_mis = 1'b1; m_fv = 1'b0;
         end else begin
            m_fv = 1'b1;
            if (!stall) m_pc = m_pc + 32'd4;
         end
         cyc++;
         m_flush = !m_halt && (cyc < flush_end);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (m_ready) begin
         chk("pc_out",      pc_out,      m_pc);
         chk("fetch_valid", fetch_valid, m_fv);
         chk("flush",       flush,       m_flush);
         chk("redirect",    redirect,    m_red);
         chk("misalign",    misalign,    m_mis);
         chk("link_addr",   link_addr,   br_pc + 32'd4);
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_br(input logic v, input logic t, input logic jal, input logic jalr,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
      br_valid = v; br_taken = t; br_is_jal = jal; br_is_jalr = jalr;
      br_pc = pc; br_imm = imm; br_rs1 = rs1;
   endtask

   task automatic clr_br();
      set_br(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   // Directed stimulus with hand-computed literal expectations.
   initial begin
      rst_n = 1'b0; stall = 1'b0;
      clr_br();
      cycle();
      // Inputs active during reset must not disturb the reset values.
      stall = 1'b1;
      set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h40, 32'h0);
      cycle();
      chk("rst_pc", pc_out, 32'hFFFF_FFF8);
      chk("rst_fv", fetch_valid, 32'd0);
      chk("rst_flush", flush, 32'd0);
      chk("rst_redirect", redirect, 32'd0);
      stall = 1'b0; clr_br();

      // Sequential wrap.
      rst_n = 1'b1;
      cycle(); chk("seq_fffc", pc_out, 32'hFFFF_FFFC); chk("seq_fv", fetch_valid, 32'd1);
      cycle(); chk("seq_wrap0", pc_out, 32'h0000_0000);
      cycle(); chk("seq_4", pc_out, 32'h0000_0004);
      set_br(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h40, 32'h0);      // not taken
      cycle(); chk("not_taken", pc_out, 32'h0000_0008);
      set_br(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h40, 32'h0);      // taken but not valid
      cycle(); chk("br_invalid", pc_out, 32'h0000_000C);

      // Taken BEQ.
      set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h40, 32'h0);
      cycle(); chk("beq_pc", pc_out, 32'h140); chk("beq_red", redirect, 32'd1); chk("beq_fl1", flush, 32'd1);
      clr_br();
      cycle(); chk("beq_pc1", pc_out, 32'h144); chk("beq_red0", redirect, 32'd0); chk("beq_fl2", flush, 32'd1);
      cycle(); chk("beq_pc2", pc_out, 32'h148); chk("beq_fl_end", flush, 32'd0);

      // JALR with bit-0 masking.
      set_br(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h4, 32'h2001);
      #1 chk("jalr_link", link_addr, 32'h304);
      cycle(); chk("jalr_pc", pc_out, 32'h2004); chk("jalr_red", redirect, 32'd1);
      clr_br();
      cycle(); chk("jalr_pc1", pc_out, 32'h2008);
      cycle(); chk("jalr_pc2", pc_out, 32'h200C); chk("jalr_fl_end", flush, 32'd0);

      // Stall and flush interaction.
      stall = 1'b1;
      cycle(); chk("stall_hold", pc_out, 32'h200C);
      set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h20, 32'h0);
      cycle(); chk("stall_redir_pc", pc_out, 32'h420); chk("stall_redir", redirect, 32'd1);
      set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h100, 32'h0);
      cycle(); chk("flush_ignore_pc", pc_out, 32'h420); chk("flush_ignore_fl", flush, 32'd1);
      cycle(); chk("flush_ignore_pc2", pc_out, 32'h420); chk("flush_over", flush, 32'd0);
      stall = 1'b0;
      set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h10, 32'h0);
      cycle(); chk("post_flush_br", pc_out, 32'h610); chk("post_flush_red", redirect, 32'd1);

      // Reset in the first flush cycle.
      rst_n = 1'b0; clr_br();
      cycle(); chk("mid_rst_pc", pc_out, 32'hFFFF_FFF8); chk("mid_rst_fl", flush, 32'd0);
      chk("mid_rst_red", redirect, 32'd0);
      rst_n = 1'b1;
      cycle(); chk("rel_pc", pc_out, 32'hFFFF_FFFC);

      // Misaligned JAL target.
      set_br(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h2, 32'h0);
      cycle(); chk("mis_flag", misalign, 32'd1); chk("mis_fv", fetch_valid, 32'd0);
      chk("mis_pc", pc_out, 32'hFFFF_FFFC); chk("mis_red", redirect, 32'd0); chk("mis_fl", flush, 32'd0);
      set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h40, 32'h0);
      for (int i = 0; i < 3; i++) begin
         stall = i[0];
         cycle();
      end
      chk("halt_pc", pc_out, 32'hFFFF_FFFC); chk("halt_mis", misalign, 32'd1);
      stall = 1'b0; rst_n = 1'b0; clr_br();
      cycle(); chk("mis_clear", misalign, 32'd0); chk("mis_rst_pc", pc_out, 32'hFFFF_FFF8);
      rst_n = 1'b1;
      cycle();

      // Misaligned JALR target (bit 1 survives the mask).
      set_br(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h1002);
      cycle(); chk("jalr_mis", misalign, 32'd1); chk("jalr_mis_pc", pc_out, 32'hFFFF_FFFC);
      clr_br(); rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle(); cycle(); chk("final_pc", pc_out, 32'h0000_0000);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
